// File: rtl/math_addsub_fab.sv
// Pipelined, segmented signed adder/subtractor with NUM_CH independent channels.
// Optional build macro MATH_ADDSUB_SAT_EN saturates overflowing channels instead of wrapping.
module math_addsub_fab #(
   parameter int WIDTH   = 16,
   parameter int LATENCY = 1,
   parameter int NUM_CH  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic                     in_valid,
   input  logic [NUM_CH-1:0]        sub,
   input  logic [WIDTH*NUM_CH-1:0]  dina,
   input  logic [WIDTH*NUM_CH-1:0]  dinb,
   output logic                     out_valid,
   output logic [WIDTH*NUM_CH-1:0]  dout,
   output logic [NUM_CH-1:0]        ovf
);

   localparam int SEG = (WIDTH + LATENCY) / (LATENCY + 1);

   typedef struct packed {
      logic             carry;
      logic [WIDTH-1:0] x;
   } seg_t;

   // Adds segment k of x and (b ^ s) into x in place; bits below the segment already
   // hold result bits, bits above still hold operand A.
   function automatic seg_t seg_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] b,
                                    input logic s, input logic cin, input int k);
      seg_t r;
      logic c;
      logic bi;
      int   lo;
      int   hi;
      lo  = k * SEG;
      hi  = (k == LATENCY) ? WIDTH : lo + SEG;
      r.x = x;
      c   = cin;
      // NOTE: blocking assignments are deliberate here; c ripples bit by bit inside one evaluation.
      for (int i = 0; i < WIDTH; i++) begin
         if (i >= lo && i < hi) begin
            bi     = b[i] ^ s;
            r.x[i] = x[i] ^ bi ^ c;
            c      = (x[i] & bi) | (c & (x[i] ^ bi));
         end
      end
      r.carry = c;
      return r;
   endfunction

   // Overflow flag and final output value; bubbles never raise ovf.
   function automatic logic [WIDTH:0] resolve(input logic v, input logic a_msb,
                                              input logic b_msb, input logic [WIDTH-1:0] r);
      logic             ov;
      logic [WIDTH-1:0] d;
      ov = v & (a_msb == b_msb) & (r[WIDTH-1] != a_msb);
      d  = v ? r : '0;
`ifdef MATH_ADDSUB_SAT_EN
      if (ov) d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      return {ov, d};
   endfunction

   if (LATENCY == 0) begin : g_comb
      assign out_valid = in_valid;
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         logic             unused_carry;
         logic [WIDTH-1:0] sum;
         assign {unused_carry, sum} = seg_add(dina[c*WIDTH +: WIDTH], dinb[c*WIDTH +: WIDTH],
                                              sub[c], sub[c], 0);
         assign {ovf[c], dout[c*WIDTH +: WIDTH]} =
            resolve(in_valid, dina[c*WIDTH+WIDTH-1], dinb[c*WIDTH+WIDTH-1] ^ sub[c], sum);
      end
   end else begin : g_pipe
      logic [LATENCY-1:0] v_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= '0;
         end else if (ena) begin
            v_q[0] <= in_valid;
            for (int k = 1; k < LATENCY; k++) v_q[k] <= v_q[k-1];
         end
      end

      assign out_valid = v_q[LATENCY-1];

      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         logic [WIDTH-1:0]   x_q [LATENCY];
         logic [WIDTH-1:0]   b_q [LATENCY];
         logic [LATENCY-1:0] s_q;
         logic [LATENCY-1:0] c_q;
         seg_t               st  [LATENCY+1];

         always_comb begin
            st[0] = seg_add(dina[c*WIDTH +: WIDTH], dinb[c*WIDTH +: WIDTH], sub[c], sub[c], 0);
            for (int k = 1; k <= LATENCY; k++)
               st[k] = seg_add(x_q[k-1], b_q[k-1], s_q[k-1], c_q[k-1], k);
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               // NOTE: data stages are cleared too, not only valid, so dout reads 0 after reset.
               for (int k = 0; k < LATENCY; k++) begin
                  x_q[k] <= '0;
                  b_q[k] <= '0;
               end
               s_q <= '0;
               c_q <= '0;
            end else if (ena) begin
               b_q[0] <= dinb[c*WIDTH +: WIDTH];
               s_q[0] <= sub[c];
               for (int k = 0; k < LATENCY; k++) begin
                  x_q[k] <= st[k].x;
                  c_q[k] <= st[k].carry;
               end
               for (int k = 1; k < LATENCY; k++) begin
                  b_q[k] <= b_q[k-1];
                  s_q[k] <= s_q[k-1];
               end
            end
         end

         // The top segment holds the operand sign bits until the last stage adds it.
         assign {ovf[c], dout[c*WIDTH +: WIDTH]} =
            resolve(v_q[LATENCY-1], x_q[LATENCY-1][WIDTH-1],
                    b_q[LATENCY-1][WIDTH-1] ^ s_q[LATENCY-1], st[LATENCY].x);
      end
   end

endmodule

// File: tb/tb_math_addsub_fab.sv
// Directed bench for math_addsub_fab: a 2-channel 16-bit/latency-1 instance and a
// 13-bit/latency-3 instance checked against an integer reference model.
module tb_math_addsub_fab;

`ifdef MATH_ADDSUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // 16-bit, latency 1, two channels
   logic        p_rst, p_ena, p_iv, p_ovl;
   logic [1:0]  p_sub, p_ovf;
   logic [31:0] p_a, p_b, p_dout;

   // 13-bit, latency 3 (segments 4/4/4/1), one channel
   logic        q_rst, q_ena, q_iv, q_ovl, q_sub, q_ovf;
   logic [12:0] q_a, q_b, q_dout;

   math_addsub_fab #(.WIDTH(16), .LATENCY(1), .NUM_CH(2)) u_p (
      .clk(clk), .rst(p_rst), .ena(p_ena), .in_valid(p_iv), .sub(p_sub),
      .dina(p_a), .dinb(p_b), .out_valid(p_ovl), .dout(p_dout), .ovf(p_ovf));

   math_addsub_fab #(.WIDTH(13), .LATENCY(3), .NUM_CH(1)) u_q (
      .clk(clk), .rst(q_rst), .ena(q_ena), .in_valid(q_iv), .sub(q_sub),
      .dina(q_a), .dinb(q_b), .out_valid(q_ovl), .dout(q_dout), .ovf(q_ovf));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] pick(input logic [15:0] sat_val, input logic [15:0] wrap_val);
      return SAT ? sat_val : wrap_val;
   endfunction

   task automatic p_step(input logic [15:0] a0, input logic [15:0] b0, input logic [15:0] a1,
                         input logic [15:0] b1, input logic [1:0] s, input logic v);
      p_a   = {a1, a0};
      p_b   = {b1, b0};
      p_sub = s;
      p_iv  = v;
      tick();
   endtask

   task automatic p_expect(input string tag, input logic v, input logic [15:0] d0,
                           input logic [15:0] d1, input logic [1:0] ov);
      chk({tag, "_valid"}, 32'(p_ovl), 32'(v));
      chk({tag, "_ovf"}, 32'(p_ovf), 32'(ov));
      if (v) begin
         chk({tag, "_ch0"}, 32'(p_dout[15:0]), 32'(d0));
         chk({tag, "_ch1"}, 32'(p_dout[31:16]), 32'(d1));
      end
   endtask

   // Reference: exact integer arithmetic, then range check and wrap/clamp.
   function automatic logic [13:0] q_model(input logic [12:0] a, input logic [12:0] b, input logic s);
      int          ai, bi, t;
      logic        ov;
      logic [12:0] d;
      ai = int'($signed(a));
      bi = int'($signed(b));
      t  = s ? ai - bi : ai + bi;
      ov = (t > 4095) || (t < -4096);
      d  = 13'(t);
      if (SAT && ov) d = (t > 0) ? 13'h0FFF : 13'h1000;
      return {ov, d};
   endfunction

   logic        hv   [0:2047];
   logic [13:0] hres [0:2047];
   int          qm = 0;

   task automatic q_cycle(input logic [12:0] a, input logic [12:0] b, input logic s,
                          input logic v, input logic e);
      logic        ev;
      logic [13:0] er;
      q_a   = a;
      q_b   = b;
      q_sub = s;
      q_iv  = v;
      q_ena = e;
      if (e) begin
         hv[qm]   = v;
         hres[qm] = q_model(a, b, s);
      end
      tick();
      if (e) qm++;
      if (qm >= 3) begin
         ev = hv[qm-3];
         er = hres[qm-3];
      end else begin
         ev = 1'b0;
         er = '0;
      end
      chk("q_valid", 32'(q_ovl), 32'(ev));
      chk("q_ovf", 32'(q_ovf), 32'(ev & er[13]));
      if (ev || qm < 3) chk("q_dout", 32'(q_dout), 32'(er[12:0]));
   endtask

   task automatic q_reset(input logic e);
      q_rst = 1'b1;
      q_ena = e;
      q_iv  = 1'b1;
      q_a   = 13'h0AAA;
      q_b   = 13'h0555;
      tick();
      q_rst = 1'b0;
      qm    = 0;
      chk("q_rst_valid", 32'(q_ovl), 32'd0);
      chk("q_rst_ovf", 32'(q_ovf), 32'd0);
      chk("q_rst_dout", 32'(q_dout), 32'd0);
   endtask

   initial begin
      p_rst = 1'b1; p_ena = 1'b0; p_iv = 1'b1; p_sub = 2'b00; p_a = '1; p_b = '1;
      q_rst = 1'b0; q_ena = 1'b0; q_iv = 1'b0; q_sub = 1'b0; q_a = '0; q_b = '0;

      // Reset with ena low must still clear the pipeline.
      tick();
      tick();
      p_rst = 1'b0;
      p_ena = 1'b1;
      chk("p_rst_valid", 32'(p_ovl), 32'd0);
      chk("p_rst_ovf", 32'(p_ovf), 32'd0);
      chk("p_rst_dout", p_dout, 32'd0);

      // Carry across the 8-bit segment boundary.
      p_step(16'h00FF, 16'h0001, 16'h1234, 16'h0001, 2'b00, 1'b1);
      p_expect("p_carry", 1'b1, 16'h0100, 16'h1235, 2'b00);
      // Subtract overflow on ch0, plain subtract on ch1.
      p_step(16'h8000, 16'h0001, 16'h0005, 16'h0007, 2'b11, 1'b1);
      p_expect("p_subovf", 1'b1, pick(16'h8000, 16'h7FFF), 16'hFFFE, 2'b01);
      // Channel independence: ch0 overflows, ch1 untouched.
      p_step(16'h7FFF, 16'h0001, 16'h0001, 16'h0001, 2'b00, 1'b1);
      p_expect("p_indep", 1'b1, pick(16'h7FFF, 16'h8000), 16'h0002, 2'b01);
      // Back-to-back samples with alternating sub.
      p_step(16'h1000, 16'h2000, 16'h1000, 16'h2000, 2'b10, 1'b1);
      p_expect("p_alt0", 1'b1, 16'h3000, 16'hF000, 2'b00);
      p_step(16'h1000, 16'h2000, 16'h1000, 16'h2000, 2'b01, 1'b1);
      p_expect("p_alt1", 1'b1, 16'hF000, 16'h3000, 2'b00);
      // Bubble carrying overflowing data: no valid, no ovf.
      p_step(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 2'b00, 1'b0);
      p_expect("p_bubble", 1'b0, 16'h0000, 16'h0000, 2'b00);
      // Negative add overflow on ch0, positive subtract overflow on ch1.
      p_step(16'h8000, 16'hFFFF, 16'h7FFF, 16'hFFFF, 2'b10, 1'b1);
      p_expect("p_ovf2", 1'b1, pick(16'h8000, 16'h7FFF), pick(16'h7FFF, 16'h8000), 2'b11);
      // -1+1 and 0-0 land on zero without overflow.
      p_step(16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 2'b10, 1'b1);
      p_expect("p_zero", 1'b1, 16'h0000, 16'h0000, 2'b00);
      // 0 - (-32768) overflows positive; -32768 - (-32768) is zero.
      p_step(16'h0000, 16'h8000, 16'h8000, 16'h8000, 2'b11, 1'b1);
      p_expect("p_minneg", 1'b1, pick(16'h7FFF, 16'h8000), 16'h0000, 2'b01);
      // Frozen while ena is low.
      p_ena = 1'b0;
      p_step(16'h1111, 16'h2222, 16'h3333, 16'h4444, 2'b00, 1'b1);
      p_expect("p_freeze", 1'b1, pick(16'h7FFF, 16'h8000), 16'h0000, 2'b01);

      // Random stream against the reference model.
      q_reset(1'b0);
      for (int n = 0; n < 1000; n++)
         q_cycle(13'($urandom), 13'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 1'b1);

      // Five disabled cycles mid-stream with junk on the inputs.
      for (int i = 0; i < 6; i++)
         q_cycle(13'(i * 517 + 3), 13'(i * 1201 + 4000), 1'(i), 1'b1, 1'b1);
      for (int i = 0; i < 5; i++)
         q_cycle(13'h1FFF, 13'h1FFF, 1'b1, 1'b1, 1'b0);
      for (int i = 6; i < 12; i++)
         q_cycle(13'(i * 517 + 3), 13'(i * 1201 + 4000), 1'(i), 1'b1, 1'b1);
      for (int i = 0; i < 4; i++)
         q_cycle(13'h0000, 13'h0000, 1'b0, 1'b0, 1'b1);

      // Reset with three samples in flight; nothing old may surface.
      q_cycle(13'h0FFF, 13'h0001, 1'b0, 1'b1, 1'b1);
      q_cycle(13'h1000, 13'h0001, 1'b1, 1'b1, 1'b1);
      q_cycle(13'h0123, 13'h0456, 1'b0, 1'b1, 1'b1);
      q_reset(1'b1);
      q_cycle(13'h0055, 13'h0022, 1'b0, 1'b0, 1'b1);
      q_cycle(13'h0055, 13'h0022, 1'b0, 1'b0, 1'b1);
      q_cycle(13'h0100, 13'h0023, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++)
         q_cycle(13'h0000, 13'h0000, 1'b0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
